// File: rtl/core_flags_pkg.sv
// Shared Z80 flag definitions: F bit positions, flag register operations and
// branch condition codes.
package core_flags_pkg;

    localparam int FLAG_C  = 0;
    localparam int FLAG_N  = 1;
    localparam int FLAG_PV = 2;
    localparam int FLAG_X3 = 3;
    localparam int FLAG_H  = 4;
    localparam int FLAG_X5 = 5;
    localparam int FLAG_Z  = 6;
    localparam int FLAG_S  = 7;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_ALU  = 3'd1,
        OP_LOAD = 3'd2,
        OP_SCF  = 3'd3,
        OP_CCF  = 3'd4,
        OP_SWAP = 3'd5
    } flag_op_e;

    typedef enum logic [2:0] {
        CC_NZ = 3'd0,
        CC_Z  = 3'd1,
        CC_NC = 3'd2,
        CC_C  = 3'd3,
        CC_PO = 3'd4,
        CC_PE = 3'd5,
        CC_P  = 3'd6,
        CC_M  = 3'd7
    } cc_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational JP/JR/CALL/RET condition evaluator against an F value.
// Shared with the branch unit.
module cond_eval
    import core_flags_pkg::*;
(
    input  logic [7:0] f,
    input  logic [2:0] cc,
    output logic       cond_true
);

    always_comb begin
        cond_true = 1'b0;
        case (cc)
            CC_NZ: cond_true = ~f[FLAG_Z];
            CC_Z:  cond_true =  f[FLAG_Z];
            CC_NC: cond_true = ~f[FLAG_C];
            CC_C:  cond_true =  f[FLAG_C];
            CC_PO: cond_true = ~f[FLAG_PV];
            CC_PE: cond_true =  f[FLAG_PV];
            CC_P:  cond_true = ~f[FLAG_S];
            CC_M:  cond_true =  f[FLAG_S];
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_register.sv
// Z80 architectural F register with main/alternate banks (EX AF,AF').
// Only the active bank is ever written; bank_sel picks which one that is.
module flag_register
    import core_flags_pkg::*;
#(
    parameter logic [7:0] RESET_VALUE = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] flag_op,
    input  logic [7:0] flag_we,
    input  logic       alu_s,
    input  logic       alu_z,
    input  logic       alu_h,
    input  logic       alu_pv,
    input  logic       alu_n,
    input  logic       alu_c,
    input  logic [7:0] alu_result,
    input  logic [7:0] a_in,
    input  logic [7:0] data_in,
    input  logic [2:0] cc,
    output logic [7:0] f_out,
    output logic [7:0] f_alt_out,
    output logic       bank_sel,
    output logic       cond_true
);

    logic [7:0] f_main;
    logic [7:0] f_alt;
    logic [7:0] f_active;
    logic [7:0] f_inactive;
    logic [7:0] f_next;
    logic [7:0] alu_flags;
    logic       bank_sel_next;
    logic       unused_bits;

    assign f_active   = bank_sel ? f_alt  : f_main;
    assign f_inactive = bank_sel ? f_main : f_alt;

    // ALU flags packed into F bit order; x flags come straight from the result.
    assign alu_flags = {alu_s, alu_z, alu_result[5], alu_h,
                        alu_result[3], alu_pv, alu_n, alu_c};

    // Only bits 5 and 3 of the result/accumulator feed the undocumented flags.
    assign unused_bits = ^{alu_result[7:6], alu_result[4], alu_result[2:0],
                           a_in[7:6], a_in[4], a_in[2:0]};

    always_comb begin
        f_next        = f_active;
        bank_sel_next = bank_sel;
        case (flag_op)
            OP_ALU:  f_next = (f_active & ~flag_we) | (alu_flags & flag_we);
            OP_LOAD: f_next = data_in;
            OP_SCF: begin
                f_next[FLAG_C]  = 1'b1;
                f_next[FLAG_H]  = 1'b0;
                f_next[FLAG_N]  = 1'b0;
                f_next[FLAG_X5] = a_in[5];
                f_next[FLAG_X3] = a_in[3];
            end
            OP_CCF: begin
                f_next[FLAG_H]  = f_active[FLAG_C];
                f_next[FLAG_C]  = ~f_active[FLAG_C];
                f_next[FLAG_N]  = 1'b0;
                f_next[FLAG_X5] = a_in[5];
                f_next[FLAG_X3] = a_in[3];
            end
            OP_SWAP: bank_sel_next = ~bank_sel;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_main   <= RESET_VALUE;
            f_alt    <= RESET_VALUE;
            bank_sel <= 1'b0;
        end else begin
            bank_sel <= bank_sel_next;
            if (bank_sel) f_alt  <= f_next;
            else          f_main <= f_next;
        end
    end

    assign f_out     = f_active;
    assign f_alt_out = f_inactive;

    cond_eval u_cond_eval (
        .f         (f_active),
        .cc        (cc),
        .cond_true (cond_true)
    );

endmodule

// File: tb/tb_flag_register.sv
// Self-checking bench for flag_register: directed plan scenarios plus random
// ops against a bank-array reference model.
module tb_flag_register;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] flag_op;
    logic [7:0] flag_we;
    logic       alu_s, alu_z, alu_h, alu_pv, alu_n, alu_c;
    logic [7:0] alu_result, a_in, data_in;
    logic [2:0] cc;
    logic [7:0] f_out, f_alt_out;
    logic       bank_sel, cond_true;

    int checks   = 0;
    int failures = 0;

    // Reference model: two banks indexed by the active-bank number.
    logic [7:0] m_bank [2];
    int         m_sel;

    flag_register #(.RESET_VALUE(8'hFF)) dut (
        .clk(clk), .rst(rst), .flag_op(flag_op), .flag_we(flag_we),
        .alu_s(alu_s), .alu_z(alu_z), .alu_h(alu_h), .alu_pv(alu_pv),
        .alu_n(alu_n), .alu_c(alu_c), .alu_result(alu_result), .a_in(a_in),
        .data_in(data_in), .cc(cc), .f_out(f_out), .f_alt_out(f_alt_out),
        .bank_sel(bank_sel), .cond_true(cond_true)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_next(input logic [7:0] f, input int op,
        input logic [7:0] we, input logic s, z, h, pv, n, c,
        input logic [7:0] res, a, d);
        logic [7:0] r;
        logic [7:0] src;
        logic       old_c;
        r = f;
        old_c = f[0];
        src[7] = s; src[6] = z; src[5] = res[5]; src[4] = h;
        src[3] = res[3]; src[2] = pv; src[1] = n; src[0] = c;
        case (op)
            1: for (int i = 0; i < 8; i++) if (we[i]) r[i] = src[i];
            2: r = d;
            3: begin r[0] = 1'b1; r[4] = 1'b0; r[1] = 1'b0; r[5] = a[5]; r[3] = a[3]; end
            4: begin r[4] = old_c; r[0] = ~old_c; r[1] = 1'b0; r[5] = a[5]; r[3] = a[3]; end
            default: ;
        endcase
        return r;
    endfunction

    // Conditions pair up: cc>>1 picks the flag (Z, C, PV, S), cc[0]=1 wants it set.
    function automatic logic model_cond(input logic [7:0] f, input int code);
        int flag_pos [4] = '{6, 0, 2, 7};
        return f[flag_pos[code / 2]] == logic'(code % 2);
    endfunction

    task automatic model_reset();
        m_bank[0] = 8'hFF;
        m_bank[1] = 8'hFF;
        m_sel = 0;
    endtask

    // Present one op for a cycle, advance the model at the edge, sample 1 after.
    task automatic drive_op(input logic [2:0] op, input logic [7:0] we,
        input logic s, z, h, pv, n, c, input logic [7:0] res, a, d);
        flag_op = op; flag_we = we;
        alu_s = s; alu_z = z; alu_h = h; alu_pv = pv; alu_n = n; alu_c = c;
        alu_result = res; a_in = a; data_in = d;
        @(posedge clk);
        if (op == 3'd5) m_sel = 1 - m_sel;
        else m_bank[m_sel] = model_next(m_bank[m_sel], int'(op), we, s, z, h, pv, n, c, res, a, d);
        #1;
        flag_op = 3'd0; flag_we = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flag_op = 3'd0; flag_we = 8'h00; cc = 3'd0;
        {alu_s, alu_z, alu_h, alu_pv, alu_n, alu_c} = 6'b0;
        alu_result = 8'h00; a_in = 8'h00; data_in = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++; if (f_out !== 8'hFF) begin failures++; $display("FAIL reset_f_out got=%h exp=ff", f_out); end
        checks++; if (f_alt_out !== 8'hFF) begin failures++; $display("FAIL reset_f_alt got=%h exp=ff", f_alt_out); end
        checks++; if (bank_sel !== 1'b0) begin failures++; $display("FAIL reset_bank_sel got=%b exp=0", bank_sel); end
        checks++; if (cond_true !== 1'b0) begin failures++; $display("FAIL reset_cond_nz got=%b exp=0", cond_true); end
    endtask

    task automatic test_alu();
        logic [2:0] codes [3] = '{3'd1, 3'd3, 3'd5};
        logic       exps  [3] = '{1'b1, 1'b1, 1'b0};
        drive_op(3'd1, 8'hFF, 0, 1, 1, 0, 0, 1, 8'h28, 8'h00, 8'h00);
        checks++; if (f_out !== 8'h79) begin failures++; $display("FAIL alu_full got=%h exp=79", f_out); end
        for (int i = 0; i < 3; i++) begin
            cc = codes[i];
            #1;
            checks++;
            if (cond_true !== exps[i]) begin
                failures++; $display("FAIL alu_cond cc=%0d got=%b exp=%b", cc, cond_true, exps[i]);
            end
        end
        drive_op(3'd1, 8'h01, 1, 0, 1, 1, 1, 0, 8'hFF, 8'h00, 8'h00);
        checks++; if (f_out !== 8'h78) begin failures++; $display("FAIL alu_mask_c got=%h exp=78", f_out); end
    endtask

    task automatic test_scf_ccf();
        drive_op(3'd4, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        checks++; if (f_out !== 8'h41) begin failures++; $display("FAIL ccf got=%h exp=41", f_out); end
        drive_op(3'd3, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h28, 8'h00);
        checks++; if (f_out !== 8'h69) begin failures++; $display("FAIL scf got=%h exp=69", f_out); end
    endtask

    task automatic test_swap();
        drive_op(3'd2, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h84);
        checks++; if (f_out !== 8'h84) begin failures++; $display("FAIL load got=%h exp=84", f_out); end
        drive_op(3'd5, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        checks++; if (bank_sel !== 1'b1) begin failures++; $display("FAIL swap_bank got=%b exp=1", bank_sel); end
        checks++; if (f_out !== 8'hFF) begin failures++; $display("FAIL swap_f_out got=%h exp=ff", f_out); end
        checks++; if (f_alt_out !== 8'h84) begin failures++; $display("FAIL swap_f_alt got=%h exp=84", f_alt_out); end
        drive_op(3'd1, 8'h80, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        checks++; if (f_out !== 8'h7F) begin failures++; $display("FAIL alt_alu got=%h exp=7f", f_out); end
        checks++; if (f_alt_out !== 8'h84) begin failures++; $display("FAIL alt_untouched got=%h exp=84", f_alt_out); end
        drive_op(3'd5, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        checks++; if (f_out !== 8'h84) begin failures++; $display("FAIL swap_back got=%h exp=84", f_out); end
        checks++; if (f_alt_out !== 8'h7F) begin failures++; $display("FAIL swap_back_alt got=%h exp=7f", f_alt_out); end
    endtask

    task automatic test_back_to_back();
        drive_op(3'd5, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        drive_op(3'd5, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        checks++; if (bank_sel !== 1'b0) begin failures++; $display("FAIL b2b_swap_bank got=%b exp=0", bank_sel); end
        checks++; if (f_out !== 8'h84) begin failures++; $display("FAIL b2b_swap_f got=%h exp=84", f_out); end
        drive_op(3'd2, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h01);
        drive_op(3'd4, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'hFF, 8'h00);
        checks++; if (f_out !== 8'h38) begin failures++; $display("FAIL b2b_load_ccf got=%h exp=38", f_out); end
        drive_op(3'd5, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        drive_op(3'd2, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h5A);
        checks++; if (f_out !== 8'h5A) begin failures++; $display("FAIL b2b_swap_load got=%h exp=5a", f_out); end
        checks++; if (f_alt_out !== 8'h38) begin failures++; $display("FAIL b2b_swap_load_alt got=%h exp=38", f_alt_out); end
    endtask

    task automatic test_reset_mid();
        // Bank 1 is active with 5A; reset must clear it before the next edge.
        flag_op = 3'd2; data_in = 8'h00;
        #2 rst = 1'b1;
        #1;
        checks++; if (f_out !== 8'hFF) begin failures++; $display("FAIL rst_mid_f got=%h exp=ff", f_out); end
        checks++; if (bank_sel !== 1'b0) begin failures++; $display("FAIL rst_mid_bank got=%b exp=0", bank_sel); end
        checks++; if (f_alt_out !== 8'hFF) begin failures++; $display("FAIL rst_mid_alt got=%h exp=ff", f_alt_out); end
        @(posedge clk);
        #1 rst = 1'b0; flag_op = 3'd0;
        model_reset();
        checks++; if (f_out !== 8'hFF) begin failures++; $display("FAIL rst_mid_hold got=%h exp=ff", f_out); end
    endtask

    task automatic test_cc_sweep();
        logic [7:0] vals [2] = '{8'h00, 8'hFF};
        for (int v = 0; v < 2; v++) begin
            drive_op(3'd2, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, vals[v]);
            for (int k = 0; k < 8; k++) begin
                logic exp_c;
                exp_c = (v == 0) ? ((k % 2) == 0) : ((k % 2) == 1);
                cc = 3'(k);
                #1;
                checks++;
                if (cond_true !== exp_c) begin
                    failures++; $display("FAIL cc_sweep f=%h cc=%0d got=%b exp=%b", f_out, k, cond_true, exp_c);
                end
            end
        end
    endtask

    task automatic test_reserved();
        drive_op(3'd2, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'hA5);
        drive_op(3'd6, 8'hFF, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        checks++; if (f_out !== 8'hA5) begin failures++; $display("FAIL reserved6 got=%h exp=a5", f_out); end
        drive_op(3'd7, 8'hFF, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h5A);
        checks++; if (f_out !== 8'hA5) begin failures++; $display("FAIL reserved7 got=%h exp=a5", f_out); end
        checks++; if (bank_sel !== 1'b0) begin failures++; $display("FAIL reserved_bank got=%b exp=0", bank_sel); end
        drive_op(3'd1, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        checks++; if (f_out !== 8'hA5) begin failures++; $display("FAIL alu_we0 got=%h exp=a5", f_out); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            logic [2:0] op;
            logic [2:0] code;
            op = 3'($urandom_range(0, 7));
            code = 3'($urandom_range(0, 7));
            cc = code;
            #1;
            checks++;
            if (cond_true !== model_cond(m_bank[m_sel], int'(code))) begin
                failures++; $display("FAIL rand_cond it=%0d cc=%0d got=%b", i, code, cond_true);
            end
            drive_op(op, 8'($urandom()), 1'($urandom()), 1'($urandom()), 1'($urandom()),
                     1'($urandom()), 1'($urandom()), 1'($urandom()),
                     8'($urandom()), 8'($urandom()), 8'($urandom()));
            checks++;
            if (f_out !== m_bank[m_sel] || f_alt_out !== m_bank[1 - m_sel] || bank_sel !== m_sel[0]) begin
                failures++;
                $display("FAIL rand_state it=%0d op=%0d got=%h/%h/%b exp=%h/%h/%0d", i, op,
                         f_out, f_alt_out, bank_sel, m_bank[m_sel], m_bank[1 - m_sel], m_sel);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_scf_ccf();
        test_swap();
        test_back_to_back();
        test_reset_mid();
        test_cc_sweep();
        test_reserved();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
